xadc_sample_filter: RTL and testbench



---
 rtl/psm_pkg.sv | 16 +
 rtl/sample_watchdog.sv | 32 +++
 rtl/xadc_sample_filter.sv | 139 +++++++++++++
 tb/tb_xadc_sample_filter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/psm_pkg.sv
// rtl/psm_pkg.sv - constants and types shared by the XADC filter and the PSM controller
package psm_pkg;

    localparam int ADC_W   = 12;
    localparam int DRP_MSB = 15;
    localparam int DRP_LSB = 4;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } filt_state_t;

    localparam logic [ADC_W-1:0] DEFAULT_REF       = 12'd3700;
    localparam logic [ADC_W-1:0] DEFAULT_THRESHOLD = 12'd64;

endpackage

// File: rtl/sample_watchdog.sv
// rtl/sample_watchdog.sv - saturating idle counter; expired while no kick for TIMEOUT_CYCLES clocks
module sample_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset_in,
    input  logic kick,
    output logic expired,
    output logic expiring
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT_LESS = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_count <= '0;
        end else if (kick) begin
            r_count <= '0;
        end else if (r_count != LIMIT) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired  = (r_count == LIMIT);
    // Lets the filter clear its state on the same edge that raises expired.
    assign expiring = !kick && (r_count == LIMIT_LESS);

endmodule

// File: rtl/xadc_sample_filter.sv
// rtl/xadc_sample_filter.sv - boxcar average of XADC DRP samples with stale-ADC watchdog
// Optional spike clamp in RUN: define XADC_SAMPLE_FILTER_SPIKE_REJECT_EN.
module xadc_sample_filter
    import psm_pkg::*;
#(
    parameter int AVG_LOG2       = 3,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SPIKE_LIMIT    = 64
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              drdy_in,
    input  logic [15:0]       do_in,
    output logic [ADC_W-1:0]  filt_out,
    output logic              filt_valid,
    output logic              primed,
    output logic              stale,
    output logic [7:0]        spike_count
);

    localparam int WIN    = 1 << AVG_LOG2;
    localparam int SUM_W  = ADC_W + AVG_LOG2;
    localparam int FILL_W = AVG_LOG2 + 1;
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(WIN - 1);

    filt_state_t        r_state, w_state_next;
    logic [ADC_W-1:0]   r_buf [WIN];
    logic [ADC_W-1:0]   r_filt, w_filt_next;
    logic               r_valid, r_primed, w_primed_next;
    logic [SUM_W-1:0]   r_sum, w_sum_d, w_sum_next;
    logic [AVG_LOG2-1:0] r_ptr, w_ptr_d;
    logic [FILL_W-1:0]  r_fill, w_fill_d;
    logic [ADC_W-1:0]   w_raw, w_s, w_old, w_avg;
    logic               w_expired, w_expiring;
    logic               w_unused_bits;

    sample_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .reset_in (reset_in),
        .kick     (drdy_in),
        .expired  (w_expired),
        .expiring (w_expiring)
    );

    assign w_raw = do_in[DRP_MSB:DRP_LSB];
    assign w_unused_bits = ^{do_in[DRP_LSB-1:0], SPIKE_LIMIT[0]};

`ifdef XADC_SAMPLE_FILTER_SPIKE_REJECT_EN
    logic [ADC_W:0] w_hi_lim;
    logic           w_clamp_hi, w_clamp_lo;
    logic [7:0]     r_spike_count;

    // 13-bit compares so filt_out + SPIKE_LIMIT cannot wrap.
    assign w_hi_lim   = {1'b0, r_filt} + (ADC_W+1)'(SPIKE_LIMIT);
    assign w_clamp_hi = (r_state == RUN) && ({1'b0, w_raw} > w_hi_lim);
    assign w_clamp_lo = (r_state == RUN) &&
                        (({1'b0, w_raw} + (ADC_W+1)'(SPIKE_LIMIT)) < {1'b0, r_filt});
    assign w_s = w_clamp_hi ? w_hi_lim[ADC_W-1:0] :
                 w_clamp_lo ? (r_filt - ADC_W'(SPIKE_LIMIT)) : w_raw;

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_spike_count <= '0;
        end else if (drdy_in && (w_clamp_hi || w_clamp_lo) && (r_spike_count != 8'hFF)) begin
            r_spike_count <= r_spike_count + 8'd1;
        end
    end
    assign spike_count = r_spike_count;
`else
    assign w_s         = w_raw;
    assign spike_count = 8'd0;
`endif

    assign w_old      = (r_state == RUN) ? r_buf[r_ptr] : '0;
    assign w_sum_next = r_sum - {{AVG_LOG2{1'b0}}, w_old} + {{AVG_LOG2{1'b0}}, w_s};
    assign w_avg      = w_sum_next[SUM_W-1:AVG_LOG2];

    always_comb begin
        w_state_next  = r_state;
        w_filt_next   = r_filt;
        w_primed_next = r_primed;
        w_sum_d       = r_sum;
        w_ptr_d       = r_ptr;
        w_fill_d      = r_fill;
        if (drdy_in) begin
            w_sum_d = w_sum_next;
            w_ptr_d = r_ptr + 1'b1;
            if (r_state == PRIME) begin
                w_fill_d    = r_fill + 1'b1;
                w_filt_next = w_s;
                if (r_fill == LAST_FILL) begin
                    w_state_next  = RUN;
                    w_primed_next = 1'b1;
                    w_filt_next   = w_avg;
                end
            end else begin
                w_filt_next = w_avg;
            end
        end else if (w_expiring) begin
            w_state_next  = PRIME;
            w_primed_next = 1'b0;
            w_sum_d       = '0;
            w_ptr_d       = '0;
            w_fill_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            r_state  <= PRIME;
            r_filt   <= '0;
            r_valid  <= 1'b0;
            r_primed <= 1'b0;
            r_sum    <= '0;
            r_ptr    <= '0;
            r_fill   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_filt   <= w_filt_next;
            r_valid  <= drdy_in;
            r_primed <= w_primed_next;
            r_sum    <= w_sum_d;
            r_ptr    <= w_ptr_d;
            r_fill   <= w_fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (drdy_in && !reset_in) begin
            r_buf[r_ptr] <= w_s;
        end
    end

    assign filt_out   = r_filt;
    assign filt_valid = r_valid;
    assign primed     = r_primed;
    assign stale      = w_expired;

endmodule

// File: tb/tb_xadc_sample_filter.sv
// tb/tb_xadc_sample_filter.sv - directed self-checking bench for xadc_sample_filter
module tb_xadc_sample_filter;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        drdy_in = 1'b0;
    logic [15:0] do_in = 16'h0;
    logic [11:0] filt_out;
    logic        filt_valid;
    logic        primed;
    logic        stale;
    logic [7:0]  spike_count;

    int n_total = 0;
    int n_bad   = 0;

    xadc_sample_filter #(
        .AVG_LOG2       (2),
        .TIMEOUT_CYCLES (100),
        .SPIKE_LIMIT    (64)
    ) dut (
        .clk         (clk),
        .reset_in    (reset_in),
        .drdy_in     (drdy_in),
        .do_in       (do_in),
        .filt_out    (filt_out),
        .filt_valid  (filt_valid),
        .primed      (primed),
        .stale       (stale),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] code);
        drdy_in = 1'b1;
        do_in   = {code, 4'h5};
        tick(1);
        drdy_in = 1'b0;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        tick(2);
        reset_in = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".filt_out"},    filt_out, 0);
        check_eq({tag, ".filt_valid"},  filt_valid, 0);
        check_eq({tag, ".primed"},      primed, 0);
        check_eq({tag, ".stale"},       stale, 0);
        check_eq({tag, ".spike_count"}, spike_count, 0);
    endtask

    task automatic prime_3700();
        for (int i = 0; i < 4; i++) begin
            send(12'd3700);
            check_eq("prime.valid", filt_valid, 1);
            check_eq("prime.filt", filt_out, 3700);
            check_eq("prime.primed", primed, (i == 3) ? 1 : 0);
        end
    endtask

    initial begin
        // 1: reset state, idle, first sample is passed through
        tick(1);
        do_reset();
        tick(10);
        check_zero("idle");
        send(12'd3600);
        check_eq("t1.valid", filt_valid, 1);
        check_eq("t1.filt", filt_out, 3600);
        check_eq("t1.primed", primed, 0);
        tick(1);
        check_eq("t1.valid_drop", filt_valid, 0);

        // 2: window fills, then first true average
        do_reset();
        prime_3700();
        send(12'd3800);
        check_eq("t2.avg", filt_out, 3725);
        check_eq("t2.primed", primed, 1);

        // 3: back-to-back samples, pointer wraps, floor average
        do_reset();
        prime_3700();
        for (int i = 0; i < 10; i++) begin
            drdy_in = 1'b1;
            do_in   = {((i % 2) == 0) ? 12'd3700 : 12'd3701, 4'h0};
            tick(1);
            check_eq("t3.valid", filt_valid, 1);
            check_eq("t3.filt", filt_out, 3700);
        end
        drdy_in = 1'b0;
        tick(1);
        check_eq("t3.valid_end", filt_valid, 0);

        // 4: watchdog expiry and recovery (one idle cycle already spent)
        tick(98);
        check_eq("t4.stale_pre", stale, 0);
        check_eq("t4.primed_pre", primed, 1);
        tick(1);
        check_eq("t4.stale", stale, 1);
        check_eq("t4.primed", primed, 0);
        tick(5);
        check_eq("t4.stale_hold", stale, 1);
        send(12'd3650);
        check_eq("t4.stale_clear", stale, 0);
        check_eq("t4.filt", filt_out, 3650);
        check_eq("t4.valid", filt_valid, 1);
        check_eq("t4.primed_after", primed, 0);

        // 5: drdy on the expiry cycle wins; then reset mid-RUN
        tick(99);
        check_eq("t5.stale_edge_pre", stale, 0);
        send(12'd3650);
        check_eq("t5.stale_edge", stale, 0);
        check_eq("t5.filt", filt_out, 3650);
        tick(1);
        check_eq("t5.stale_after", stale, 0);
        send(12'd3650);
        send(12'd3650);
        check_eq("t5.primed", primed, 1);
        check_eq("t5.run_filt", filt_out, 3650);
        drdy_in  = 1'b1;
        do_in    = {12'd4000, 4'h0};
        reset_in = 1'b1;
        tick(1);
        reset_in = 1'b0;
        drdy_in  = 1'b0;
        check_zero("t5.rst");
        send(12'd1234);
        check_eq("t5.post_rst_filt", filt_out, 1234);
        check_eq("t5.post_rst_primed", primed, 0);

        // 6: out-of-range sample in RUN
        do_reset();
        prime_3700();
        send(12'd4000);
`ifdef XADC_SAMPLE_FILTER_SPIKE_REJECT_EN
        check_eq("t6.filt", filt_out, 3716);
        check_eq("t6.spikes", spike_count, 1);
`else
        check_eq("t6.filt", filt_out, 3775);
        check_eq("t6.spikes", spike_count, 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
